// File: rtl/cpu_int_sequencer.sv
// Interrupt acknowledge sequencer: ACK strobes, return-address push,
// vector load, plus the interrupt master enable and HALT wake logic.
module cpu_int_sequencer #(
  parameter int unsigned ACK_CYCLES = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        int_n,
  input  logic [7:0]  jump_addr,
  output logic        m1_n,
  output logic        iorq_n,
  input  logic        instr_boundary,
  input  logic        halt,
  input  logic        ei,
  input  logic        di,
  input  logic        reti,
  input  logic [15:0] pc,
  output logic        stall,
  output logic        push_req,
  output logic [15:0] push_data,
  input  logic        push_ack,
  output logic        pc_load,
  output logic [15:0] pc_new,
  output logic        ime,
  output logic        halt_wake
);

  typedef enum logic [2:0] {
    IDLE,
    ACK,
    RELEASE,
    PUSH,
    VECTOR
  } state_t;

  localparam logic [3:0] CNT_LOAD = 4'(ACK_CYCLES - 1);

  state_t      state_q;
  state_t      state_d;
  logic [3:0]  cnt_q;
  logic [7:0]  jaddr_q;
  logic        ei_pend_q;
  logic        wake_prev_q;
  logic        in_idle;
  logic        take;
  logic        wake_cond;

  assign in_idle   = (state_q == IDLE);
  assign take      = in_idle & ime & ~int_n
                   & (instr_boundary | halt);
  assign wake_cond = in_idle & halt & ~int_n;

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next state and per-state strobes
  always_comb begin
    state_d  = state_q;
    m1_n     = 1'b1;
    iorq_n   = 1'b1;
    stall    = 1'b0;
    push_req = 1'b0;
    pc_load  = 1'b0;
    pc_new   = 16'h0000;
    case (state_q)
      IDLE: begin
        if (take) state_d = ACK;
      end
      ACK: begin
        m1_n   = 1'b0;
        iorq_n = 1'b0;
        stall  = 1'b1;
        if (cnt_q == 4'd0) state_d = RELEASE;
      end
      RELEASE: begin
        stall   = 1'b1;
        state_d = PUSH;
      end
      PUSH: begin
        stall    = 1'b1;
        push_req = 1'b1;
        if (push_ack) state_d = VECTOR;
      end
      VECTOR: begin
        stall   = 1'b1;
        pc_load = 1'b1;
        pc_new  = {8'h00, jaddr_q};
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Latch vector and return address on accept; run ACK counter
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q     <= 4'd0;
      jaddr_q   <= 8'h00;
      push_data <= 16'h0000;
    end else if (take) begin
      cnt_q     <= CNT_LOAD;
      jaddr_q   <= jump_addr;
      push_data <= pc;
    end else if (state_q == ACK && cnt_q != 4'd0) begin
      cnt_q <= cnt_q - 4'd1;
    end
  end

  // Master enable: decoder pulses only honoured while idle
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ime       <= 1'b0;
      ei_pend_q <= 1'b0;
    end else if (in_idle) begin
      if (take || di) begin
        ime       <= 1'b0;
        ei_pend_q <= 1'b0;
      end else if (reti) begin
        ime <= 1'b1;
      end else if (ei) begin
        ei_pend_q <= 1'b1;
      end else if (ei_pend_q && instr_boundary) begin
        ime       <= 1'b1;
        ei_pend_q <= 1'b0;
      end
    end
  end

  // One wake pulse per onset of a pending request while halted
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      halt_wake   <= 1'b0;
      wake_prev_q <= 1'b0;
    end else begin
      halt_wake   <= wake_cond & ~wake_prev_q;
      wake_prev_q <= wake_cond;
    end
  end

endmodule

// File: tb/tb_cpu_int_sequencer.sv
// Bench for cpu_int_sequencer: vector table fed through an
// expected-result queue, plus an async reset mid-acknowledge.
module tb_cpu_int_sequencer;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        int_n = 1'b1;
  logic [7:0]  jump_addr = 8'h00;
  logic        m1_n;
  logic        iorq_n;
  logic        instr_boundary = 1'b0;
  logic        halt = 1'b0;
  logic        ei = 1'b0;
  logic        di = 1'b0;
  logic        reti = 1'b0;
  logic [15:0] pc = 16'h0000;
  logic        stall;
  logic        push_req;
  logic [15:0] push_data;
  logic        push_ack = 1'b0;
  logic        pc_load;
  logic [15:0] pc_new;
  logic        ime;
  logic        halt_wake;

  cpu_int_sequencer #(.ACK_CYCLES(4)) dut (
    .clock(clock),
    .reset(reset),
    .int_n(int_n),
    .jump_addr(jump_addr),
    .m1_n(m1_n),
    .iorq_n(iorq_n),
    .instr_boundary(instr_boundary),
    .halt(halt),
    .ei(ei),
    .di(di),
    .reti(reti),
    .pc(pc),
    .stall(stall),
    .push_req(push_req),
    .push_data(push_data),
    .push_ack(push_ack),
    .pc_load(pc_load),
    .pc_new(pc_new),
    .ime(ime),
    .halt_wake(halt_wake)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic        int_n;
    logic [7:0]  jaddr;
    logic        ib;
    logic        halt;
    logic        ei;
    logic        di;
    logic        reti;
    logic        ack;
    logic [15:0] pc;
  } in_t;

  typedef struct packed {
    logic        m1_n;
    logic        iorq_n;
    logic        stall;
    logic        push_req;
    logic        pc_load;
    logic [15:0] pc_new;
    logic        ime;
    logic        halt_wake;
    logic [15:0] push_data;
  } obs_t;

  typedef struct {
    string name;
    in_t   in;
    obs_t  exp;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];
  int   checks = 0;
  int   errors = 0;

  function automatic in_t mk_in(
    logic n, logic [7:0] ja, logic ib, logic h,
    logic e, logic d, logic r, logic a, logic [15:0] p);
    in_t v;
    v.int_n = n;
    v.jaddr = ja;
    v.ib    = ib;
    v.halt  = h;
    v.ei    = e;
    v.di    = d;
    v.reti  = r;
    v.ack   = a;
    v.pc    = p;
    return v;
  endfunction

  function automatic obs_t mk_out(
    logic m1, logic io, logic st, logic pr, logic pl,
    logic [15:0] pn, logic im, logic hw, logic [15:0] pd);
    obs_t o;
    o.m1_n      = m1;
    o.iorq_n    = io;
    o.stall     = st;
    o.push_req  = pr;
    o.pc_load   = pl;
    o.pc_new    = pn;
    o.ime       = im;
    o.halt_wake = hw;
    o.push_data = pd;
    return o;
  endfunction

  function automatic obs_t o_idle(logic im, logic hw, logic [15:0] pd);
    return mk_out(1, 1, 0, 0, 0, 16'h0000, im, hw, pd);
  endfunction

  function automatic obs_t o_ack(logic [15:0] pd, logic hw);
    return mk_out(0, 0, 1, 0, 0, 16'h0000, 0, hw, pd);
  endfunction

  function automatic obs_t o_rel(logic [15:0] pd);
    return mk_out(1, 1, 1, 0, 0, 16'h0000, 0, 0, pd);
  endfunction

  function automatic obs_t o_push(logic [15:0] pd);
    return mk_out(1, 1, 1, 1, 0, 16'h0000, 0, 0, pd);
  endfunction

  function automatic obs_t o_vec(logic [15:0] pd, logic [15:0] pn);
    return mk_out(1, 1, 1, 0, 1, pn, 0, 0, pd);
  endfunction

  function automatic obs_t sample();
    return mk_out(m1_n, iorq_n, stall, push_req, pc_load,
                  pc_new, ime, halt_wake, push_data);
  endfunction

  function automatic void add(string nm, in_t i, obs_t e);
    vec_t v;
    v.name = nm;
    v.in   = i;
    v.exp  = e;
    tbl.push_back(v);
  endfunction

  task automatic drive(input in_t i);
    int_n          = i.int_n;
    jump_addr      = i.jaddr;
    instr_boundary = i.ib;
    halt           = i.halt;
    ei             = i.ei;
    di             = i.di;
    reti           = i.reti;
    push_ack       = i.ack;
    pc             = i.pc;
  endtask

  task automatic check(input string nm, input obs_t e);
    obs_t a;
    a = sample();
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got m1_n=%b iorq_n=%b stall=%b push_req=%b pc_load=%b pc_new=%h ime=%b halt_wake=%b push_data=%h ; expected m1_n=%b iorq_n=%b stall=%b push_req=%b pc_load=%b pc_new=%h ime=%b halt_wake=%b push_data=%h",
        nm, a.m1_n, a.iorq_n, a.stall, a.push_req, a.pc_load,
        a.pc_new, a.ime, a.halt_wake, a.push_data,
        e.m1_n, e.iorq_n, e.stall, e.push_req, e.pc_load,
        e.pc_new, e.ime, e.halt_wake, e.push_data);
    end
  endtask

  task automatic step(input string nm, input in_t i, input obs_t e);
    vec_t v;
    drive(i);
    v.name = nm;
    v.in   = i;
    v.exp  = e;
    sb.push_back(v);
    @(posedge clock);
    #1;
    v = sb.pop_front();
    check(v.name, v.exp);
  endtask

  initial begin
    // ei+di together, then reti
    add("ei_di_same", mk_in(1, 8'h00, 0, 0, 1, 1, 0, 0, 16'h0), o_idle(0, 0, 16'h0));
    add("ib_no_pend", mk_in(1, 8'h00, 1, 0, 0, 0, 0, 0, 16'h0), o_idle(0, 0, 16'h0));
    add("reti_set",   mk_in(1, 8'h00, 0, 0, 0, 0, 1, 0, 16'h0), o_idle(1, 0, 16'h0));
    add("ime_hold",   mk_in(1, 8'h00, 0, 0, 0, 0, 0, 0, 16'h0), o_idle(1, 0, 16'h0));
    // basic acknowledge, int_n released and ei/reti ignored mid-sequence
    add("take",       mk_in(0, 8'hA4, 1, 0, 0, 0, 0, 0, 16'h1234), o_ack(16'h1234, 0));
    add("ack_c2",     mk_in(0, 8'hA4, 0, 0, 0, 0, 0, 0, 16'h1234), o_ack(16'h1234, 0));
    add("ack_c3_hi",  mk_in(1, 8'h55, 0, 0, 0, 0, 0, 0, 16'h0), o_ack(16'h1234, 0));
    add("ack_c4_ei",  mk_in(1, 8'h55, 0, 0, 1, 0, 0, 0, 16'h0), o_ack(16'h1234, 0));
    add("release",    mk_in(1, 8'h55, 0, 0, 0, 0, 0, 0, 16'h0), o_rel(16'h1234));
    add("push_reti",  mk_in(1, 8'h55, 0, 0, 0, 0, 1, 0, 16'h0), o_push(16'h1234));
    add("vector",     mk_in(1, 8'h55, 0, 0, 0, 0, 0, 1, 16'h0), o_vec(16'h1234, 16'h00A4));
    add("idle_back",  mk_in(1, 8'h00, 0, 0, 0, 0, 0, 0, 16'h0), o_idle(0, 0, 16'h1234));
    add("ei_ignored", mk_in(1, 8'h00, 1, 0, 0, 0, 0, 0, 16'h0), o_idle(0, 0, 16'h1234));
    add("int_no_ime", mk_in(0, 8'h77, 1, 0, 0, 0, 0, 0, 16'h0), o_idle(0, 0, 16'h1234));
    // halt wake with ime clear
    add("halt_wake",  mk_in(0, 8'h77, 0, 1, 0, 0, 0, 0, 16'h0), o_idle(0, 1, 16'h1234));
    add("halt_once",  mk_in(0, 8'h77, 0, 1, 0, 0, 0, 0, 16'h0), o_idle(0, 0, 16'h1234));
    add("halt_hold",  mk_in(0, 8'h77, 0, 1, 0, 0, 0, 0, 16'h0), o_idle(0, 0, 16'h1234));
    // acknowledge taken from HALT, push_ack withheld 10 cycles
    add("reti_again", mk_in(1, 8'h00, 0, 0, 0, 0, 1, 0, 16'h0), o_idle(1, 0, 16'h1234));
    add("halt_take",  mk_in(0, 8'hC3, 0, 1, 0, 0, 0, 0, 16'hBEEF), o_ack(16'hBEEF, 1));
    for (int k = 0; k < 3; k++)
      add($sformatf("h_ack_%0d", k + 2),
          mk_in(1, 8'h00, 0, 0, 0, 0, 0, 0, 16'h0), o_ack(16'hBEEF, 0));
    add("h_release",  mk_in(1, 8'h00, 0, 0, 0, 0, 0, 0, 16'h0), o_rel(16'hBEEF));
    for (int k = 0; k < 10; k++)
      add($sformatf("push_wait_%0d", k),
          mk_in(1, 8'h00, 0, 0, 0, 0, 0, 0, 16'h0), o_push(16'hBEEF));
    add("h_vector",   mk_in(1, 8'h00, 0, 0, 0, 0, 0, 1, 16'h0), o_vec(16'hBEEF, 16'h00C3));
    add("h_idle",     mk_in(1, 8'h00, 0, 0, 0, 0, 0, 0, 16'h0), o_idle(0, 0, 16'hBEEF));
    add("stray_ack",  mk_in(1, 8'h00, 0, 0, 0, 0, 0, 1, 16'h0), o_idle(0, 0, 16'hBEEF));
    // ei delay: first boundary enables, second takes
    add("ei_pend",    mk_in(0, 8'h10, 0, 0, 1, 0, 0, 0, 16'h2000), o_idle(0, 0, 16'hBEEF));
    add("ib1_no_ack", mk_in(0, 8'h10, 1, 0, 0, 0, 0, 0, 16'h2000), o_idle(1, 0, 16'hBEEF));
    add("between",    mk_in(0, 8'h10, 0, 0, 0, 0, 0, 0, 16'h2000), o_idle(1, 0, 16'hBEEF));
    add("ib2_take",   mk_in(0, 8'h10, 1, 0, 0, 0, 0, 0, 16'h2000), o_ack(16'h2000, 0));

    drive(mk_in(1, 8'h00, 0, 0, 0, 0, 0, 0, 16'h0));
    #3;
    check("reset_state", o_idle(0, 0, 16'h0));
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #1;

    foreach (tbl[i]) step(tbl[i].name, tbl[i].in, tbl[i].exp);

    // async reset during ACK cycle 2
    step("r_ack_c2", mk_in(0, 8'h10, 0, 0, 0, 0, 0, 0, 16'h2000),
         o_ack(16'h2000, 0));
    #2;
    reset = 1'b1;
    #1;
    check("reset_async", o_idle(0, 0, 16'h0));
    @(posedge clock);
    #1;
    check("reset_held", o_idle(0, 0, 16'h0));
    reset = 1'b0;
    for (int k = 0; k < 8; k++)
      step($sformatf("post_reset_%0d", k),
           mk_in(1, 8'h00, 0, 0, 0, 0, 0, 1, 16'h0), o_idle(0, 0, 16'h0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cpu_int_sequencer.md
CPU_INT_SEQUENCER -- requirements
Module: cpu_int_sequencer

Interface
REQ-001 Parameter: ACK_CYCLES, default 4, number of cycles m1_n/iorq_n are held low per acknowledge (legal range 3..15).
REQ-002 clock  input  1  system clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 int_n  input  1  active-low interrupt request from the interrupt controller.
REQ-005 jump_addr  input  8  vector low byte from the interrupt controller, valid while int_n is low.
REQ-006 m1_n, iorq_n  output  1 each  active-low acknowledge strobes to the interrupt controller.
REQ-007 instr_boundary  input  1  one-cycle pulse when the core completes an instruction.
REQ-008 halt  input  1  core is in HALT.
REQ-009 ei, di, reti  input  1 each  one-cycle pulses from the decoder.
REQ-010 pc  input  16  current program counter (the return address).
REQ-011 stall  output  1  freezes the core while servicing.
REQ-012 push_req  output  1; push_data  output  16; push_ack  input  1  stack-write handshake.
REQ-013 pc_load  output  1; pc_new  output  16  one-cycle PC overwrite.
REQ-014 ime  output  1  interrupt master enable.
REQ-015 halt_wake  output  1  one-cycle pulse releasing the core from HALT.

Function
REQ-016 States: IDLE, ACK, RELEASE, PUSH, VECTOR; single registered state machine.
REQ-017 IDLE->ACK when ime=1, int_n=0, and (instr_boundary=1 or halt=1); same edge: latch jump_addr, latch pc into push_data, clear ime, clear ei_pending, load ack counter with ACK_CYCLES-1.
REQ-018 ACK: m1_n=0, iorq_n=0, stall=1; counter decrements each cycle; ACK->RELEASE when counter=0 (exactly ACK_CYCLES cycles low).
REQ-019 RELEASE: m1_n=1, iorq_n=1, stall=1 for one cycle, then ->PUSH.
REQ-020 PUSH: push_req=1, stall=1, push_data stable; ->VECTOR on the cycle push_ack=1; push_req held indefinitely otherwise.
REQ-021 VECTOR: pc_load=1, pc_new={8'h00, latched jump_addr}, stall=1 for one cycle, then ->IDLE.
REQ-022 Outside ACK, m1_n=1 and iorq_n=1; outside ACK/RELEASE/PUSH/VECTOR, stall=0 and push_req=0.
REQ-023 ei sets ei_pending; ime becomes 1 on the first instr_boundary strictly after the ei cycle; an interrupt is not taken on that same boundary.
REQ-024 di clears ime and ei_pending on the next edge; di takes priority over ei/reti in the same cycle.
REQ-025 reti sets ime on the next edge (no delay).
REQ-026 halt=1 and int_n=0 in IDLE: halt_wake pulses one cycle regardless of ime; if ime=0 no acknowledge is issued.
REQ-027 ei/di/reti pulses arriving outside IDLE are ignored; ime stays 0 until VECTOR completes.
REQ-028 int_n rising during ACK does not abort the sequence; latched jump_addr is used.
REQ-029 int_n still low on return to IDLE is ignored until ime is set again.

Reset
REQ-030 On reset assertion, asynchronously: state=IDLE, m1_n=1, iorq_n=1, stall=0, push_req=0, push_data=0, pc_load=0, pc_new=0, ime=0, ei_pending=0, halt_wake=0, counter=0.
REQ-031 Reset asserted mid-sequence returns to IDLE immediately; no push or pc_load is issued afterward.

Verification
REQ-032 ime=1, pc=16'h1234, int_n=0, jump_addr=8'hA4, instr_boundary pulse -> m1_n/iorq_n low exactly 4 cycles, push_data=16'h1234, after push_ack pc_load pulse with pc_new=16'h00A4, ime=0.
REQ-033 ei pulse, int_n=0, two instr_boundary pulses -> no acknowledge at first boundary, ime=1 after it, acknowledge begins at second.
REQ-034 ime=0, halt=1, int_n=0 -> single halt_wake pulse, m1_n/iorq_n stay 1, stall=0.
REQ-035 push_ack withheld 10 cycles -> push_req and stall held 10 cycles, pc_load only the cycle after push_ack.
REQ-036 ei and di in same cycle -> ime=0, ei_pending=0; reti later -> ime=1 next cycle.
REQ-037 reset asserted during ACK cycle 2 -> all outputs at reset values immediately, no pc_load after release.
